i2c_reg_arbiter: RTL and testbench

Shares one synchronous-read register RAM (32 x 8) between the I2C slave's register port and a local host port. The I2C side issues fire-and-forget read/write pulses. These are buffered and serviced with fixed priority. The host side uses a req/gnt handshake and is protected from starvation by a streak limit. The block sits between the I2C slave engine and the RAM macro.

---
 rtl/i2c_pkg.sv | 15 +
 rtl/i2c_req_latch.sv | 76 +++++++
 rtl/i2c_reg_arbiter.sv | 163 ++++++++++++++++
 tb/tb_i2c_reg_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C/host register RAM arbiter.
package i2c_pkg;

    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 8;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACC_I2C  = 2'd1,
        ST_ACC_HOST = 2'd2,
        ST_RET      = 2'd3
    } state_e;

endpackage

// File: rtl/i2c_req_latch.sv
// One-entry buffer for fire-and-forget I2C access pulses.
// Sticky overflow flags any pulse that cannot be held.
module i2c_req_latch
    import i2c_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          clr_i,
    output logic          pend_o,
    output logic          ent_we_o,
    output logic [AW-1:0] ent_addr_o,
    output logic [DW-1:0] ent_wdata_o,
    output logic          ovf_o
);

    logic          pend_q, pend_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ovf_q, ovf_d;
    logic          full;

    // An entry being handed to the FSM this cycle frees the slot.
    assign full = pend_q & ~clr_i;

    always_comb begin
        pend_d  = full;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        if (we_i | re_i) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                pend_d  = 1'b1;
                we_d    = we_i;
                addr_d  = addr_i;
                wdata_d = wdata_i;
            end
            if (we_i & re_i) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pend_o      = pend_q;
    assign ent_we_o    = we_q;
    assign ent_addr_o  = addr_q;
    assign ent_wdata_o = wdata_q;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Arbitrates a synchronous-read register RAM between the I2C slave
// port (buffered, priority) and a host req/gnt port (streak-limited).
module i2c_reg_arbiter
    import i2c_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i2c_addr,
    input  logic [DW-1:0] i2c_wdata,
    input  logic          i2c_we,
    input  logic          i2c_re,
    output logic [DW-1:0] i2c_rdata,
    output logic          i2c_rvalid,
    output logic          i2c_ovf,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_e                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  own_host_q, own_host_d;
    logic                  rd_q, rd_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DW-1:0]         i2c_rdata_q, i2c_rdata_d;
    logic                  i2c_rv_q, i2c_rv_d;
    logic [DW-1:0]         host_rdata_q, host_rdata_d;
    logic                  host_rv_q, host_rv_d;

    logic                  pend, ent_we, clr;
    logic [AW-1:0]         ent_addr;
    logic [DW-1:0]         ent_wdata;
    logic                  starve;

    i2c_req_latch #(.AW(AW), .DW(DW)) u_latch (
        .clk         (clk),
        .reset       (reset),
        .we_i        (i2c_we),
        .re_i        (i2c_re),
        .addr_i      (i2c_addr),
        .wdata_i     (i2c_wdata),
        .clr_i       (clr),
        .pend_o      (pend),
        .ent_we_o    (ent_we),
        .ent_addr_o  (ent_addr),
        .ent_wdata_o (ent_wdata),
        .ovf_o       (i2c_ovf)
    );

    assign starve = host_req &&
                    (streak_q == STREAK_W'(STARVE_LIMIT));

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        own_host_d   = own_host_q;
        rd_d         = rd_q;
        en_d         = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i2c_rdata_d  = i2c_rdata_q;
        i2c_rv_d     = 1'b0;
        host_rdata_d = host_rdata_q;
        host_rv_d    = 1'b0;
        clr          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend && !starve) begin
                    state_d    = ST_ACC_I2C;
                    en_d       = 1'b1;
                    we_d       = ent_we;
                    addr_d     = ent_addr;
                    wdata_d    = ent_wdata;
                    clr        = 1'b1;
                    own_host_d = 1'b0;
                    rd_d       = ~ent_we;
                    streak_d   = host_req ? streak_q + 1'b1 : '0;
                end else if (host_req) begin
                    state_d    = ST_ACC_HOST;
                    en_d       = 1'b1;
                    we_d       = host_we;
                    addr_d     = host_addr;
                    wdata_d    = host_wdata;
                    own_host_d = 1'b1;
                    rd_d       = ~host_we;
                    streak_d   = '0;
                end
            end
            ST_ACC_I2C, ST_ACC_HOST: begin
                state_d = ST_RET;
            end
            ST_RET: begin
                state_d = ST_IDLE;
                if (rd_q && own_host_q) begin
                    host_rdata_d = ram_rdata;
                    host_rv_d    = 1'b1;
                end else if (rd_q) begin
                    i2c_rdata_d = ram_rdata;
                    i2c_rv_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            streak_q     <= '0;
            own_host_q   <= 1'b0;
            rd_q         <= 1'b0;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i2c_rdata_q  <= '0;
            i2c_rv_q     <= 1'b0;
            host_rdata_q <= '0;
            host_rv_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            own_host_q   <= own_host_d;
            rd_q         <= rd_d;
            en_q         <= en_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i2c_rdata_q  <= i2c_rdata_d;
            i2c_rv_q     <= i2c_rv_d;
            host_rdata_q <= host_rdata_d;
            host_rv_q    <= host_rv_d;
        end
    end

    assign host_gnt    = (state_q == ST_ACC_HOST);
    assign ram_en      = en_q;
    assign ram_we      = we_q;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign i2c_rdata   = i2c_rdata_q;
    assign i2c_rvalid  = i2c_rv_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rv_q;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Randomized and directed bench for i2c_reg_arbiter against a
// shadow-memory model with cycle-latency expectations.
module tb_i2c_reg_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] i2c_addr;
    logic [DW-1:0] i2c_wdata;
    logic          i2c_we, i2c_re;
    logic [DW-1:0] i2c_rdata;
    logic          i2c_rvalid, i2c_ovf;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] shadow [32];
    int            n_chk = 0;
    int            n_fail = 0;
    int            b2b = 0;
    int            wr_total = 0;
    logic          en_prev = 1'b0;

    always #5 clk = ~clk;

    i2c_reg_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk         (clk),
        .reset       (reset),
        .i2c_addr    (i2c_addr),
        .i2c_wdata   (i2c_wdata),
        .i2c_we      (i2c_we),
        .i2c_re      (i2c_re),
        .i2c_rdata   (i2c_rdata),
        .i2c_rvalid  (i2c_rvalid),
        .i2c_ovf     (i2c_ovf),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // RAM macro stand-in; preloads a known pattern while reset is low.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 1);
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (ram_en && en_prev) b2b++;
        if (ram_en && ram_we) wr_total++;
        en_prev = ram_en;
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 32; i++) shadow[i] = 8'(i * 7 + 1);
    endtask

    task automatic outs_zero(string tag);
        chk(tag, 64'({i2c_rdata, i2c_rvalid, i2c_ovf, host_gnt,
                      host_rdata, host_rvalid, ram_en, ram_we,
                      ram_addr, ram_wdata}), 64'(0));
    endtask

    task automatic i2c_wr(input logic [4:0] a, input logic [7:0] d,
                          output int lat);
        bit found = 0;
        lat = 0;
        i2c_we = 1'b1; i2c_addr = a; i2c_wdata = d;
        for (int k = 1; k <= 12 && !found; k++) begin
            step;
            i2c_we = 1'b0;
            if (ram_en && ram_we) begin
                found = 1;
                lat = k;
                chk("i2c_wr_ram", 64'({ram_addr, ram_wdata}), 64'({a, d}));
            end
        end
        chk("i2c_wr_seen", 64'(found), 64'(1));
        step;
        step;
        shadow[a] = d;
    endtask

    task automatic i2c_rd(input logic [4:0] a, output int lat);
        bit found = 0;
        lat = 0;
        i2c_re = 1'b1; i2c_addr = a;
        for (int k = 1; k <= 12 && !found; k++) begin
            step;
            i2c_re = 1'b0;
            if (i2c_rvalid) begin
                found = 1;
                lat = k;
                chk("i2c_rd_data", 64'(i2c_rdata), 64'(shadow[a]));
            end
        end
        chk("i2c_rd_seen", 64'(found), 64'(1));
    endtask

    task automatic host_acc(input logic w, input logic [4:0] a,
                            input logic [7:0] d);
        bit found = 0;
        int glat = 0;
        host_req = 1'b1; host_we = w; host_addr = a; host_wdata = d;
        for (int k = 1; k <= 40 && !found; k++) begin
            step;
            if (host_gnt) begin
                found = 1;
                glat = k;
                host_req = 1'b0;
                chk("host_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}),
                    64'({1'b1, w, a, d}));
            end
        end
        host_req = 1'b0;
        chk("host_gnt_seen", 64'(found), 64'(1));
        chk("host_gnt_lat", 64'(glat), 64'(1));
        if (w) begin
            step;
            step;
            shadow[a] = d;
        end else begin
            found = 0;
            for (int j = 1; j <= 5 && !found; j++) begin
                step;
                if (host_rvalid) begin
                    found = 1;
                    chk("host_rd_lat", 64'(j), 64'(2));
                    chk("host_rd_data", 64'(host_rdata), 64'(shadow[a]));
                end
            end
            chk("host_rv_seen", 64'(found), 64'(1));
        end
    endtask

    initial begin
        int lat, cnt, fe, fh, gc, ic, hc, n_i2c, nw, op;
        logic [7:0] id, hd, wa, wd;
        bit gs, rv_seen;
        logic [4:0] ra;
        logic [7:0] rd8;

        reset = 1'b0;
        i2c_addr = '0; i2c_wdata = '0; i2c_we = 0; i2c_re = 0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        model_reset();
        repeat (3) step;
        outs_zero("rst_outs_in_reset");
        reset = 1'b1;
        cnt = 0;
        repeat (20) begin
            step;
            cnt += int'(ram_en);
        end
        chk("idle_ram_en", 64'(cnt), 64'(0));
        outs_zero("rst_outs_idle");

        i2c_wr(5'd3, 8'h5A, lat);
        chk("i2c_wr_lat", 64'(lat), 64'(2));
        repeat (10) step;
        i2c_rd(5'd3, lat);
        chk("i2c_rd_lat", 64'(lat), 64'(4));
        chk("i2c_rd_5a", 64'(i2c_rdata), 64'(8'h5A));
        chk("ovf_low", 64'(i2c_ovf), 64'(0));

        // I2C pulse lands first; host joins while I2C is being granted.
        fe = 0; fh = 0; gc = 0; ic = 0; hc = 0; id = 0; hd = 0;
        i2c_re = 1'b1; i2c_addr = 5'd7;
        for (int c = 1; c < 16; c++) begin
            step;
            i2c_re = 1'b0;
            if (c == 1) begin
                host_req = 1'b1; host_we = 1'b0; host_addr = 5'd3;
            end
            if (ram_en && fe == 0) begin
                fe = c;
                fh = int'(host_gnt);
            end
            if (host_gnt) begin
                gc = c;
                host_req = 1'b0;
            end
            if (i2c_rvalid) begin ic = c; id = i2c_rdata; end
            if (host_rvalid) begin hc = c; hd = host_rdata; end
        end
        chk("cont_first_en", 64'({fe, fh}), 64'({32'd2, 32'd0}));
        chk("cont_gnt_cyc", 64'(gc), 64'(5));
        chk("cont_i2c_rv", 64'({ic, 24'd0, id}), 64'({32'd4, 24'd0, shadow[7]}));
        chk("cont_host_rv", 64'({hc, 24'd0, hd}), 64'({32'd7, 24'd0, shadow[3]}));

        // I2C write every 3 cycles; host waits behind the streak limit.
        gs = 0; gc = 0; n_i2c = 0; nw = 0; hc = 0; hd = 0;
        for (int c = 0; c < 32; c++) begin
            if (host_gnt && !gs) begin gs = 1; gc = c; end
            if (ram_en && !host_gnt && host_req) n_i2c++;
            if (ram_en && ram_we) nw++;
            if (host_rvalid) begin hc = c; hd = host_rdata; end
            i2c_we = (c % 3 == 0) && !gs;
            i2c_addr = 5'(16 + c / 3);
            i2c_wdata = 8'(c);
            host_req = (c >= 2) && !gs;
            host_we = 1'b0; host_addr = 5'd3;
            step;
        end
        i2c_we = 1'b0; host_req = 1'b0;
        for (int k = 0; k < 6; k++) shadow[16 + k] = 8'(3 * k);
        chk("starve_i2c_cnt", 64'(n_i2c), 64'(LIM));
        chk("starve_gnt_cyc", 64'(gc), 64'(17));
        chk("starve_host_rv", 64'({hc, 24'd0, hd}), 64'({32'd19, 24'd0, shadow[3]}));
        chk("starve_writes", 64'(nw), 64'(6));
        chk("starve_no_ovf", 64'(i2c_ovf), 64'(0));
        i2c_rd(5'd21, lat);

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 3));
            ra = 5'($urandom_range(0, 31));
            rd8 = 8'($urandom);
            unique case (op)
                0: begin
                    i2c_wr(ra, rd8, lat);
                    chk("rnd_wr_lat", 64'(lat), 64'(2));
                end
                1: begin
                    i2c_rd(ra, lat);
                    chk("rnd_rd_lat", 64'(lat), 64'(4));
                end
                2: host_acc(1'b1, ra, rd8);
                default: host_acc(1'b0, ra, rd8);
            endcase
        end

        // Two I2C writes back-to-back behind a host access.
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd0;
        step;
        chk("ovf_gnt", 64'(host_gnt), 64'(1));
        host_req = 1'b0;
        i2c_we = 1'b1; i2c_addr = 5'd9; i2c_wdata = 8'hA1;
        step;
        i2c_addr = 5'd10; i2c_wdata = 8'hB2;
        step;
        i2c_we = 1'b0;
        nw = 0; wa = 0; wd = 0;
        repeat (12) begin
            step;
            if (ram_en && ram_we) begin nw++; wa = 8'(ram_addr); wd = ram_wdata; end
        end
        chk("ovf_flag", 64'(i2c_ovf), 64'(1));
        chk("ovf_one_write", 64'({nw, 8'd0, wa, wd}), 64'({32'd1, 8'd0, 8'd9, 8'hA1}));
        shadow[9] = 8'hA1;
        i2c_rd(5'd10, lat);
        i2c_rd(5'd9, lat);
        chk("ovf_sticky", 64'(i2c_ovf), 64'(1));

        // Reset lands in the ACC_HOST cycle of a host write.
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd5; host_wdata = 8'hC3;
        step;
        chk("rst_pre_gnt", 64'(host_gnt), 64'(1));
        #2 reset = 1'b0;
        #1;
        outs_zero("rst_mid_outs");
        host_req = 1'b0;
        cnt = wr_total;
        repeat (3) step;
        model_reset();
        reset = 1'b1;
        rv_seen = 0;
        repeat (10) begin
            step;
            if (host_rvalid || host_gnt || ram_en) rv_seen = 1;
        end
        chk("rst_no_activity", 64'(rv_seen), 64'(0));
        chk("rst_no_write", 64'(wr_total), 64'(cnt));
        host_acc(1'b0, 5'd5, 8'h00);
        host_acc(1'b1, 5'd5, 8'hC3);
        host_acc(1'b0, 5'd5, 8'h00);

        // Simultaneous we/re: write survives, read is lost.
        i2c_we = 1'b1; i2c_re = 1'b1; i2c_addr = 5'd12; i2c_wdata = 8'h33;
        nw = 0; cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step;
            i2c_we = 1'b0; i2c_re = 1'b0;
            if (ram_en && ram_we) nw++;
            if (i2c_rvalid) cnt++;
        end
        shadow[12] = 8'h33;
        chk("both_one_write", 64'(nw), 64'(1));
        chk("both_no_read", 64'(cnt), 64'(0));
        chk("both_ovf", 64'(i2c_ovf), 64'(1));
        i2c_rd(5'd12, lat);

        chk("no_b2b_strobe", 64'(b2b), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
